// File: rtl/sw_time_counter.sv
// Stopwatch timebase: 100 Hz prescaler feeding a carry-chained BCD time register (SS.hh).
// Optional lap-freeze display hold is enabled by defining SW_LAP_EN.
module sw_time_counter #(
   parameter int TICK_DIV = 1000000,
   parameter int LIM_H    = 10,
   parameter int LIM_T    = 10,
   parameter int LIM_S    = 10,
   parameter int LIM_ST   = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        clear,
`ifdef SW_LAP_EN
   input  logic        lap,
`endif
   output logic [15:0] digits,
   output logic        running,
   output logic        wrap
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [3:0] LIM_M1 [4] = '{4'(LIM_H - 1), 4'(LIM_T - 1),
                                          4'(LIM_S - 1), 4'(LIM_ST - 1)};

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic [15:0]   live, live_next;
   logic          tick, zero, carry;

   // Button inputs are single-cycle pulses; each asserted cycle is one event.
   always_comb begin
      state_next = state;
      zero       = 1'b0;
      case (state)
         IDLE:    if (start_stop) state_next = RUN;
         RUN:     if (start_stop) state_next = PAUSE;
         PAUSE: begin
            if (clear) begin
               state_next = IDLE;
               zero       = 1'b1;
            end else if (start_stop) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tick = (state == RUN) && (presc == PW'(TICK_DIV - 1));

   always_comb begin
      presc_next = presc;
      if (zero)
         presc_next = '0;
      else if (state == RUN)
         presc_next = tick ? '0 : presc + 1'b1;
   end

   // Each stage wraps at its limit and passes the carry on within the same cycle.
   always_comb begin
      live_next = live;
      carry     = tick;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (live[i*4 +: 4] >= LIM_M1[i]) begin
               live_next[i*4 +: 4] = 4'd0;
            end else begin
               live_next[i*4 +: 4] = live[i*4 +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
      if (zero)
         live_next = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= '0;
         live    <= '0;
         running <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state   <= state_next;
         presc   <= presc_next;
         live    <= live_next;
         running <= (state_next == RUN);
         wrap    <= carry;
      end
   end

`ifdef SW_LAP_EN
   logic        frozen;
   logic [15:0] snap;

   // The snapshot is the value on display at the lap edge; counting carries on underneath.
   always_ff @(posedge clk) begin
      if (reset) begin
         frozen <= 1'b0;
         snap   <= '0;
      end else if (start_stop || clear) begin
         frozen <= 1'b0;
      end else if (lap && state == RUN) begin
         frozen <= ~frozen;
         snap   <= live;
      end
   end

   assign digits = frozen ? snap : live;
`else
   assign digits = live;
`endif

endmodule

// File: tb/tb_sw_time_counter.sv
// Bench for sw_time_counter: directed steps plus random button traffic, checked every cycle
// against a hundredths-count model; lap steps are added when SW_LAP_EN is defined.
module tb_sw_time_counter;

   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        reset, start_stop, clear, lap;
   logic [15:0] digits;
   logic        running, wrap;

   int errors = 0;
   int checks = 0;

   // model state: time in hundredths of a second, prescaler phase, run/hold flags
   int          m_cnt = 0, m_presc = 0;
   bit          m_run = 0, m_held = 0, m_wrap = 0, m_frozen = 0;
   logic [15:0] m_snap = '0;
   logic [17:0] exp_q[$];

   sw_time_counter #(.TICK_DIV(TD)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .clear      (clear),
`ifdef SW_LAP_EN
      .lap        (lap),
`endif
      .digits     (digits),
      .running    (running),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int c);
      return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit tick;
      tick   = m_run && (m_presc == TD - 1);
      m_wrap = 1'b0;
      if (reset) begin
         m_cnt = 0; m_presc = 0; m_run = 0; m_held = 0; m_frozen = 0; m_snap = '0;
      end else begin
`ifdef SW_LAP_EN
         if (start_stop || clear) m_frozen = 0;
         else if (lap && m_run) begin
            m_frozen = !m_frozen;
            m_snap   = to_bcd(m_cnt);
         end
`endif
         if (tick) begin
            m_wrap = (m_cnt == 5999);
            m_cnt  = (m_cnt + 1) % 6000;
         end
         if (m_run) m_presc = (m_presc + 1) % TD;
         if (m_run) begin
            if (start_stop) begin m_run = 0; m_held = 1; end
         end else if (m_held) begin
            if (clear) begin m_held = 0; m_cnt = 0; m_presc = 0; end
            else if (start_stop) begin m_run = 1; m_held = 0; end
         end else if (start_stop) begin
            m_run = 1;
         end
      end
      exp_q.push_back({m_run, m_wrap, (m_frozen ? m_snap : to_bcd(m_cnt))});
   endtask

   task automatic cycle();
      logic [17:0] exp;
      model_edge();
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check("digits", digits, exp[15:0]);
      check("wrap", wrap, exp[16]);
      check("running", running, exp[17]);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic pulse(input bit ss, input bit clr);
      start_stop = ss; clear = clr;
      cycle();
      start_stop = 0; clear = 0;
   endtask

   task automatic do_reset();
      reset = 1; cycle(); reset = 0;
   endtask

   task automatic run_until(input int target, input int budget);
      int n = 0;
      while (m_cnt != target && n < budget) begin cycle(); n++; end
      if (n >= budget) begin
         checks++; errors++;
         $error("FAIL run_until: observed=%0d expected=%0d", m_cnt, target);
      end
   endtask

   initial begin
      int wraps;
      reset = 1; start_stop = 1; clear = 0; lap = 0;
      run(3);
      check("reset_digits", digits, 16'h0000);
      check("reset_running", running, 1'b0);
      reset = 0; start_stop = 0;
      cycle();

      pulse(1, 0);
      run(40);
      check("first_40", digits, 16'h0010);
      check("first_40_running", running, 1'b1);

      // random button traffic, occasional reset
      for (int i = 0; i < 600; i++) begin
         start_stop = ($urandom_range(0, 15) == 0);
         clear      = ($urandom_range(0, 7) == 0);
         lap        = ($urandom_range(0, 11) == 0);
         reset      = ($urandom_range(0, 199) == 0);
         cycle();
      end
      start_stop = 0; clear = 0; lap = 0; reset = 0;

      do_reset();
      pulse(1, 0);
      run_until(5999, 30000);
      check("at_5999", digits, 16'h5999);
      wraps = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (wrap) begin
            wraps++;
            check("wrap_digits", digits, 16'h0000);
         end
      end
      check("wrap_count", wraps, 1);
      check("wrap_still_running", running, 1'b1);

      do_reset();
      pulse(1, 0);
      run_until(123, 2000);
      pulse(1, 0);
      run(20);
      check("pause_hold", digits, 16'h0123);
      check("pause_running", running, 1'b0);
      pulse(0, 1);
      check("clear_digits", digits, 16'h0000);
      check("clear_running", running, 1'b0);

      pulse(1, 0);
      run_until(37, 500);
      pulse(0, 1);
      check("clear_in_run_digits", digits, 16'h0037);
      check("clear_in_run_running", running, 1'b1);
      pulse(1, 0);
      pulse(1, 1);
      check("both_in_pause_digits", digits, 16'h0000);
      check("both_in_pause_running", running, 1'b0);
      pulse(1, 1);
      check("both_in_idle_running", running, 1'b1);

      // reset landing on a tick edge
      run(6);
      for (int i = 0; i < TD && m_presc != TD - 1; i++) cycle();
      do_reset();
      check("reset_mid_tick_digits", digits, 16'h0000);
      check("reset_mid_tick_running", running, 1'b0);

`ifdef SW_LAP_EN
      pulse(1, 0);
      run_until(5, 200);
      lap = 1; cycle(); lap = 0;
      run(8 * TD);
      check("lap_frozen", digits, 16'h0005);
      lap = 1; cycle(); lap = 0;
      check("lap_release", digits, 16'h0013);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
